// File: rtl/regfile_pkg.sv
// Shared types and defaults for the dual-write register file with
// pending-load scoreboard. No ports; imported by the interface, the top
// module and the scoreboard sub-module.
package regfile_pkg;

    localparam int unsigned REG_N  = 8;   // default data width
    localparam int unsigned REG_AW = 5;   // default address width

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [REG_N-1:0]  reg_word_t;

    localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Bus bundle for regfile_scoreboard.
//   master: issue/writeback side (drives writes, reserves, read addresses)
//   slave : register file side (returns read data, busy, ack, stall, status)
interface regfile_scoreboard_if
    import regfile_pkg::*;
#(
    parameter int unsigned N  = REG_N,
    parameter int unsigned AW = REG_AW
);
    logic          alu_we;
    logic [AW-1:0] alu_waddr;
    logic [N-1:0]  alu_wdata;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [N-1:0]  mem_wdata;
    logic          rsv_en;
    logic [AW-1:0] rsv_addr;
    logic          rsv_ack;
    logic [AW-1:0] r_addr1;
    logic [AW-1:0] r_addr2;
    logic [N-1:0]  reg_data1;
    logic [N-1:0]  reg_data2;
    logic          busy1;
    logic          busy2;
    logic          stall;
    logic [AW-1:0] pending_cnt;
    logic          err;

    modport master (
        output alu_we, alu_waddr, alu_wdata,
        output mem_we, mem_waddr, mem_wdata,
        output rsv_en, rsv_addr, r_addr1, r_addr2,
        input  rsv_ack, reg_data1, reg_data2, busy1, busy2,
        input  stall, pending_cnt, err
    );

    modport slave (
        input  alu_we, alu_waddr, alu_wdata,
        input  mem_we, mem_waddr, mem_wdata,
        input  rsv_en, rsv_addr, r_addr1, r_addr2,
        output rsv_ack, reg_data1, reg_data2, busy1, busy2,
        output stall, pending_cnt, err
    );
endinterface

// File: rtl/regfile_scoreboard_sb.sv
// reg_scoreboard: per-register pending-load busy bits, busy counter and
// sticky protocol-error flag.
//   clock, reset            : clock, async active-low reset
//   alu_we_i/alu_waddr_i    : ALU writeback (for WAW error detection)
//   mem_we_i/mem_waddr_i    : load writeback, releases reservation
//   rsv_en_i/rsv_addr_i     : reserve request; rsv_ack_o accepts it
//   r_addr1_i/r_addr2_i     : read addresses; busy1_o/busy2_o per port
//   pending_cnt_o, err_o    : busy register count, sticky error
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned AW     = REG_AW,
    parameter bit          BYPASS = 1'b1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          alu_we_i,
    input  logic [AW-1:0] alu_waddr_i,
    input  logic          mem_we_i,
    input  logic [AW-1:0] mem_waddr_i,
    input  logic          rsv_en_i,
    input  logic [AW-1:0] rsv_addr_i,
    input  logic [AW-1:0] r_addr1_i,
    input  logic [AW-1:0] r_addr2_i,
    output logic          rsv_ack_o,
    output logic          busy1_o,
    output logic          busy2_o,
    output logic [AW-1:0] pending_cnt_o,
    output logic          err_o
);
    localparam int unsigned DEPTH = 1 << AW;
    localparam logic [AW-1:0] ZR = AW'(ZERO_REG);

    logic [DEPTH-1:0] busy_q, busy_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;

    logic mem_nz, alu_nz, set, clr, inc;

    assign mem_nz = mem_we_i && (mem_waddr_i != ZR);
    assign alu_nz = alu_we_i && (alu_waddr_i != ZR);

    assign rsv_ack_o = rsv_en_i && ((rsv_addr_i == ZR) || !busy_q[rsv_addr_i] ||
                                    (mem_we_i && (mem_waddr_i == rsv_addr_i)));
    assign set = rsv_ack_o && (rsv_addr_i != ZR);
    // A release that coincides with a re-reserve of the same register is not a clear.
    assign clr = mem_nz && busy_q[mem_waddr_i] && !(set && (rsv_addr_i == mem_waddr_i));
    // Count tracks the busy population: a set on an already-busy register adds nothing.
    assign inc = set && !busy_q[rsv_addr_i];

    always_comb begin
        busy_d = busy_q;
        if (mem_nz) busy_d[mem_waddr_i] = 1'b0;
        if (set)    busy_d[rsv_addr_i]  = 1'b1;

        cnt_d = cnt_q;
        if (inc && !clr)      cnt_d = cnt_q + AW'(1);
        else if (clr && !inc) cnt_d = cnt_q - AW'(1);

        err_d = err_q
              | (alu_nz && mem_nz && (alu_waddr_i == mem_waddr_i))
              | (mem_nz && !busy_q[mem_waddr_i])
              | (alu_nz && busy_q[alu_waddr_i]);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign busy1_o = (r_addr1_i != ZR) && busy_q[r_addr1_i] &&
                     !(BYPASS && mem_we_i && (mem_waddr_i == r_addr1_i));
    assign busy2_o = (r_addr2_i != ZR) && busy_q[r_addr2_i] &&
                     !(BYPASS && mem_we_i && (mem_waddr_i == r_addr2_i));

    assign pending_cnt_o = cnt_q;
    assign err_o         = err_q;
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 2-write / 2-read register file (r0 hardwired to zero)
// with pending-load scoreboard and optional write-to-read bypass.
//   clock  : rising-edge clock
//   reset  : asynchronous, active-low
//   bus    : regfile_scoreboard_if.slave (writes, reserve, reads, status)
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned N      = REG_N,
    parameter int unsigned AW     = REG_AW,
    parameter bit          BYPASS = 1'b1
) (
    input logic                 clock,
    input logic                 reset,
    regfile_scoreboard_if.slave bus
);
    localparam int unsigned DEPTH = 1 << AW;
    localparam logic [AW-1:0] ZR = AW'(ZERO_REG);

    logic [N-1:0]  rf_q [DEPTH];
    logic [N-1:0]  rf_d [DEPTH];
    logic [AW-1:0] raddr [2];
    logic [N-1:0]  rdata [2];

    // mem write applied last so it wins a same-address collision.
    always_comb begin
        rf_d = rf_q;
        if (bus.alu_we && (bus.alu_waddr != ZR)) rf_d[bus.alu_waddr] = bus.alu_wdata;
        if (bus.mem_we && (bus.mem_waddr != ZR)) rf_d[bus.mem_waddr] = bus.mem_wdata;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) rf_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) rf_q[i] <= rf_d[i];
        end
    end

    assign raddr[0] = bus.r_addr1;
    assign raddr[1] = bus.r_addr2;

    always_comb begin
        for (int unsigned p = 0; p < 2; p++) begin
            rdata[p] = rf_q[raddr[p]];
            if (BYPASS) begin
                if (bus.alu_we && (bus.alu_waddr == raddr[p])) rdata[p] = bus.alu_wdata;
                if (bus.mem_we && (bus.mem_waddr == raddr[p])) rdata[p] = bus.mem_wdata;
            end
            if (raddr[p] == ZR) rdata[p] = '0;
        end
    end

    assign bus.reg_data1 = rdata[0];
    assign bus.reg_data2 = rdata[1];

    reg_scoreboard #(.AW(AW), .BYPASS(BYPASS)) u_sb (
        .clock         (clock),
        .reset         (reset),
        .alu_we_i      (bus.alu_we),
        .alu_waddr_i   (bus.alu_waddr),
        .mem_we_i      (bus.mem_we),
        .mem_waddr_i   (bus.mem_waddr),
        .rsv_en_i      (bus.rsv_en),
        .rsv_addr_i    (bus.rsv_addr),
        .r_addr1_i     (bus.r_addr1),
        .r_addr2_i     (bus.r_addr2),
        .rsv_ack_o     (bus.rsv_ack),
        .busy1_o       (bus.busy1),
        .busy2_o       (bus.busy2),
        .pending_cnt_o (bus.pending_cnt),
        .err_o         (bus.err)
    );

    assign bus.stall = bus.busy1 | bus.busy2 | (bus.rsv_en & ~bus.rsv_ack);
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Testbench for regfile_scoreboard: one BYPASS=1 and one BYPASS=0 instance
// share the same stimulus; expected observations are queued as stimulus is
// applied and drained against each instance's outputs mid-cycle.
module tb_regfile_scoreboard;
    logic clock;
    logic reset;

    regfile_scoreboard_if #(.N(8), .AW(5)) if1 ();
    regfile_scoreboard_if #(.N(8), .AW(5)) if0 ();

    regfile_scoreboard #(.N(8), .AW(5), .BYPASS(1'b1)) dut1 (
        .clock (clock), .reset (reset), .bus (if1.slave));
    regfile_scoreboard #(.N(8), .AW(5), .BYPASS(1'b0)) dut0 (
        .clock (clock), .reset (reset), .bus (if0.slave));

    assign if0.alu_we    = if1.alu_we;
    assign if0.alu_waddr = if1.alu_waddr;
    assign if0.alu_wdata = if1.alu_wdata;
    assign if0.mem_we    = if1.mem_we;
    assign if0.mem_waddr = if1.mem_waddr;
    assign if0.mem_wdata = if1.mem_wdata;
    assign if0.rsv_en    = if1.rsv_en;
    assign if0.rsv_addr  = if1.rsv_addr;
    assign if0.r_addr1   = if1.r_addr1;
    assign if0.r_addr2   = if1.r_addr2;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // {d1, d2, busy1, busy2, stall, rsv_ack, pending_cnt, err}
    logic [25:0] obs1, obs0;
    assign obs1 = {if1.reg_data1, if1.reg_data2, if1.busy1, if1.busy2, if1.stall,
                   if1.rsv_ack, if1.pending_cnt, if1.err};
    assign obs0 = {if0.reg_data1, if0.reg_data2, if0.busy1, if0.busy2, if0.stall,
                   if0.rsv_ack, if0.pending_cnt, if0.err};

    typedef struct {
        string       name;
        bit          dut0;
        logic [25:0] v;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        x;
    logic [25:0] got;
    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  model [32];

    function automatic logic [25:0] pk(logic [7:0] d1, logic [7:0] d2, logic b1, logic b2,
                                       logic st, logic ack, logic [4:0] cnt, logic e);
        return {d1, d2, b1, b2, st, ack, cnt, e};
    endfunction

    task automatic push2(string n, logic [25:0] v1, logic [25:0] v0);
        exp_q.push_back('{name: n, dut0: 1'b0, v: v1});
        exp_q.push_back('{name: n, dut0: 1'b1, v: v0});
    endtask

    task automatic drive(logic awe, logic [4:0] aa, logic [7:0] ad,
                         logic mwe, logic [4:0] ma, logic [7:0] md,
                         logic re, logic [4:0] ra, logic [4:0] a1, logic [4:0] a2);
        if1.alu_we = awe; if1.alu_waddr = aa; if1.alu_wdata = ad;
        if1.mem_we = mwe; if1.mem_waddr = ma; if1.mem_wdata = md;
        if1.rsv_en = re;  if1.rsv_addr  = ra;
        if1.r_addr1 = a1; if1.r_addr2 = a2;
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        for (int a = 0; a < 32; a++) begin
            if1.r_addr1 = 5'(a);
            if1.r_addr2 = 5'(31 - a);
            push2("reset_read", pk(0, 0, 0, 0, 0, 0, 0, 0), pk(0, 0, 0, 0, 0, 0, 0, 0));
            #1;
            while (exp_q.size() != 0) begin
                x = exp_q.pop_front(); got = x.dut0 ? obs0 : obs1; vectors++;
                if (got !== x.v) begin
                    miscompares++;
                    $display("FAIL %s bypass=%0d got %h want %h", x.name, !x.dut0, got, x.v);
                end
            end
        end
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 32; i++) model[i] = 8'h00;
    endtask

    task automatic test_alu_bypass();
        cyc();
        drive(1, 3, 8'hA5, 0, 0, 0, 0, 0, 3, 0);
        push2("alu_same_cycle", pk(8'hA5, 0, 0, 0, 0, 0, 0, 0), pk(8'h00, 0, 0, 0, 0, 0, 0, 0));
        model[3] = 8'hA5;
        #3;
        while (exp_q.size() != 0) begin
            x = exp_q.pop_front(); got = x.dut0 ? obs0 : obs1; vectors++;
            if (got !== x.v) begin
                miscompares++;
                $display("FAIL %s bypass=%0d got %h want %h", x.name, !x.dut0, got, x.v);
            end
        end
        cyc();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 3, 0);
        push2("alu_next_cycle", pk(8'hA5, 0, 0, 0, 0, 0, 0, 0), pk(8'hA5, 0, 0, 0, 0, 0, 0, 0));
        #3;
        while (exp_q.size() != 0) begin
            x = exp_q.pop_front(); got = x.dut0 ? obs0 : obs1; vectors++;
            if (got !== x.v) begin
                miscompares++;
                $display("FAIL %s bypass=%0d got %h want %h", x.name, !x.dut0, got, x.v);
            end
        end
    endtask

    task automatic test_reserve();
        for (int c = 0; c < 4; c++) begin
            cyc();
            case (c)
                0: begin
                    drive(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
                    push2("rsv_accept", pk(0, 0, 0, 0, 0, 1, 0, 0), pk(0, 0, 0, 0, 0, 1, 0, 0));
                end
                1: begin
                    drive(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
                    push2("rsv_reject", pk(0, 0, 1, 0, 1, 0, 1, 0), pk(0, 0, 1, 0, 1, 0, 1, 0));
                end
                2: begin
                    drive(0, 0, 0, 1, 7, 8'h3C, 0, 0, 7, 0);
                    push2("load_return", pk(8'h3C, 0, 0, 0, 0, 0, 1, 0),
                          pk(8'h00, 0, 1, 0, 1, 0, 1, 0));
                    model[7] = 8'h3C;
                end
                default: begin
                    drive(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
                    push2("after_release", pk(8'h3C, 0, 0, 0, 0, 0, 0, 0),
                          pk(8'h3C, 0, 0, 0, 0, 0, 0, 0));
                end
            endcase
            #3;
            while (exp_q.size() != 0) begin
                x = exp_q.pop_front(); got = x.dut0 ? obs0 : obs1; vectors++;
                if (got !== x.v) begin
                    miscompares++;
                    $display("FAIL %s bypass=%0d got %h want %h", x.name, !x.dut0, got, x.v);
                end
            end
        end
    endtask

    task automatic test_release_reserve();
        for (int c = 0; c < 5; c++) begin
            cyc();
            case (c)
                0: begin
                    drive(0, 0, 0, 0, 0, 0, 1, 4, 4, 0);
                    push2("rr_first_rsv", pk(0, 0, 0, 0, 0, 1, 0, 0), pk(0, 0, 0, 0, 0, 1, 0, 0));
                end
                1: begin
                    drive(0, 0, 0, 1, 4, 8'h5A, 1, 4, 4, 0);
                    push2("rr_same_cycle", pk(8'h5A, 0, 0, 0, 0, 1, 1, 0),
                          pk(8'h00, 0, 1, 0, 1, 1, 1, 0));
                    model[4] = 8'h5A;
                end
                2: begin
                    drive(0, 0, 0, 0, 0, 0, 0, 0, 4, 0);
                    push2("rr_still_busy", pk(8'h5A, 0, 1, 0, 1, 0, 1, 0),
                          pk(8'h5A, 0, 1, 0, 1, 0, 1, 0));
                end
                3: begin
                    drive(0, 0, 0, 1, 4, 8'h5A, 0, 0, 0, 4);
                    push2("rr_release", pk(0, 8'h5A, 0, 0, 0, 0, 1, 0),
                          pk(0, 8'h5A, 0, 1, 1, 0, 1, 0));
                end
                default: begin
                    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 4);
                    push2("rr_cleared", pk(0, 8'h5A, 0, 0, 0, 0, 0, 0),
                          pk(0, 8'h5A, 0, 0, 0, 0, 0, 0));
                end
            endcase
            #3;
            while (exp_q.size() != 0) begin
                x = exp_q.pop_front(); got = x.dut0 ? obs0 : obs1; vectors++;
                if (got !== x.v) begin
                    miscompares++;
                    $display("FAIL %s bypass=%0d got %h want %h", x.name, !x.dut0, got, x.v);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] v;
        for (int i = 1; i <= 6; i++) begin
            cyc();
            v = 8'(i * 16 + 3);
            drive(1, 5'(i), v, 0, 0, 0, 0, 0, 5'(i), 5'(i - 1));
            push2("b2b_write", pk(v, model[i-1], 0, 0, 0, 0, 0, 0),
                  pk(model[i], model[i-1], 0, 0, 0, 0, 0, 0));
            model[i] = v;
            #3;
            while (exp_q.size() != 0) begin
                x = exp_q.pop_front(); got = x.dut0 ? obs0 : obs1; vectors++;
                if (got !== x.v) begin
                    miscompares++;
                    $display("FAIL %s bypass=%0d got %h want %h", x.name, !x.dut0, got, x.v);
                end
            end
        end
    endtask

    task automatic test_dual_write();
        cyc();
        drive(1, 9, 8'h11, 1, 9, 8'h22, 0, 0, 9, 0);
        push2("dual_same_cycle", pk(8'h22, 0, 0, 0, 0, 0, 0, 0), pk(8'h00, 0, 0, 0, 0, 0, 0, 0));
        #3;
        while (exp_q.size() != 0) begin
            x = exp_q.pop_front(); got = x.dut0 ? obs0 : obs1; vectors++;
            if (got !== x.v) begin
                miscompares++;
                $display("FAIL %s bypass=%0d got %h want %h", x.name, !x.dut0, got, x.v);
            end
        end
        cyc();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
        push2("dual_next_err", pk(8'h22, 0, 0, 0, 0, 0, 0, 1), pk(8'h22, 0, 0, 0, 0, 0, 0, 1));
        #3;
        while (exp_q.size() != 0) begin
            x = exp_q.pop_front(); got = x.dut0 ? obs0 : obs1; vectors++;
            if (got !== x.v) begin
                miscompares++;
                $display("FAIL %s bypass=%0d got %h want %h", x.name, !x.dut0, got, x.v);
            end
        end
    endtask

    task automatic test_r0();
        cyc();
        drive(1, 0, 8'hFF, 0, 0, 0, 1, 0, 0, 0);
        push2("r0_write_rsv", pk(0, 0, 0, 0, 0, 1, 0, 1), pk(0, 0, 0, 0, 0, 1, 0, 1));
        #3;
        while (exp_q.size() != 0) begin
            x = exp_q.pop_front(); got = x.dut0 ? obs0 : obs1; vectors++;
            if (got !== x.v) begin
                miscompares++;
                $display("FAIL %s bypass=%0d got %h want %h", x.name, !x.dut0, got, x.v);
            end
        end
        cyc();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        push2("r0_after", pk(0, 0, 0, 0, 0, 0, 0, 1), pk(0, 0, 0, 0, 0, 0, 0, 1));
        #3;
        while (exp_q.size() != 0) begin
            x = exp_q.pop_front(); got = x.dut0 ? obs0 : obs1; vectors++;
            if (got !== x.v) begin
                miscompares++;
                $display("FAIL %s bypass=%0d got %h want %h", x.name, !x.dut0, got, x.v);
            end
        end
    endtask

    task automatic test_reset_midrun();
        cyc();
        drive(1, 12, 8'h77, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        drive(0, 0, 0, 0, 0, 0, 1, 12, 0, 0);
        cyc();
        drive(0, 0, 0, 0, 0, 0, 1, 12, 12, 0);
        push2("pre_reset", pk(8'h77, 0, 1, 0, 1, 0, 1, 1), pk(8'h77, 0, 1, 0, 1, 0, 1, 1));
        #2;
        while (exp_q.size() != 0) begin
            x = exp_q.pop_front(); got = x.dut0 ? obs0 : obs1; vectors++;
            if (got !== x.v) begin
                miscompares++;
                $display("FAIL %s bypass=%0d got %h want %h", x.name, !x.dut0, got, x.v);
            end
        end
        reset = 1'b0;
        push2("async_reset", pk(0, 0, 0, 0, 0, 1, 0, 0), pk(0, 0, 0, 0, 0, 1, 0, 0));
        #1;
        while (exp_q.size() != 0) begin
            x = exp_q.pop_front(); got = x.dut0 ? obs0 : obs1; vectors++;
            if (got !== x.v) begin
                miscompares++;
                $display("FAIL %s bypass=%0d got %h want %h", x.name, !x.dut0, got, x.v);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu_bypass();
        test_reserve();
        test_release_reserve();
        test_back_to_back();
        test_dual_write();
        test_r0();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Two-write-port, two-read-port general-purpose register file with a per-register pending-load scoreboard, used in the picoRISC datapath in place of the single-write-port register bank. The ALU writeback and the memory (load) writeback land in the same cycle without arbitration stalls. Registers reserved by an issued load read as busy until the load data returns. Optional write-to-read bypass removes the one-cycle writeback bubble.

## Interface
- `N`, 8: data width in bits.
- `AW`, 5: address width; depth = 2^AW registers, register 0 hardwired to zero.
- `BYPASS`, 1: 1 = same-cycle write data forwarded to read ports; 0 = reads return stored contents only.

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low.
- `alu_we`  in  1  ALU writeback enable.
- `alu_waddr`  in  AW  ALU writeback address.
- `alu_wdata`  in  N  ALU writeback data.
- `mem_we`  in  1  load writeback enable; also releases the reservation.
- `mem_waddr`  in  AW  load writeback address.
- `mem_wdata`  in  N  load writeback data.
- `rsv_en`  in  1  reserve request from issue stage (load issued).
- `rsv_addr`  in  AW  register to mark busy.
- `rsv_ack`  out  1  reservation accepted (combinational).
- `r_addr1`, `r_addr2`  in  AW  read addresses.
- `reg_data1`, `reg_data2`  out  N  read data (combinational).
- `busy1`, `busy2`  out  1  addressed register has a pending load.
- `stall`  out  1  busy1 | busy2 | (rsv_en & ~rsv_ack).
- `pending_cnt`  out  AW  number of busy registers.
- `err`  out  1  sticky protocol-error flag.

## Operation
- Reset: all registers 0, all busy bits 0, pending_cnt 0, err 0.
- Register 0: reads always return 0 with busy 0. Writes to it are dropped. Reservations of it are acked with no state change.
- Writes commit on the rising edge.
- If alu_we and mem_we both target the same nonzero address, the mem write wins and err is set.
- Reserve:
  - rsv_ack = rsv_en & (rsv_addr==0 | ~busy[rsv_addr] | releasing[rsv_addr]), where releasing means mem_we to the same address this cycle.
  - Accepted reserve sets busy[rsv_addr] at the next edge.
  - A rejected reserve (register still busy, no release this cycle) changes no state.
- Release: mem_we clears busy[mem_waddr] at the next edge, unless an accepted reserve targets the same address in the same cycle. In that case busy stays 1, the data is written, and pending_cnt is unchanged.
- mem_we to a register that is not busy: data is still written and err is set.
- alu_we to a busy register: data is written and err is set (issue logic must prevent WAW).
- pending_cnt is incremented on accepted set, decremented on clear, unchanged when both occur. It never exceeds 2^AW−1, since register 0 is never busy.
- err clears only on reset.
- Bypass (BYPASS=1):
  - A read address matching an active write this cycle returns that write data, with mem priority over ALU.
  - busy for an address being released this cycle reads 0.
- BYPASS=0: reads and busy reflect registered state only.

## Timing
- Read-to-data latency: 0 cycles, combinational from r_addr and state.
- Write-to-read visibility: same cycle with BYPASS=1; next cycle with BYPASS=0.
- Reserve-to-busy: busy visible the cycle after rsv_ack.
- Release-to-not-busy:
  - BYPASS=1: same cycle.
  - BYPASS=0: next cycle.
- Reset asserted mid-operation clears state immediately and asynchronously. Combinational outputs follow the cleared state: reg_data 0, busy 0, rsv_ack = rsv_en & (rsv_addr==0 | 1), i.e. equal to rsv_en.
- No output has a registered path from clock other than through state.

## Structure
- Package `regfile_pkg`:
  - default N/AW localparams;
  - `typedef logic [AW-1:0] reg_addr_t`;
  - `typedef logic [N-1:0] reg_word_t`;
  - constant `ZERO_REG = '0`.
- Sub-module `reg_scoreboard`:
  - busy vector, pending_cnt, err and the rsv_ack / release logic.
  - The top module holds the storage array, write arbitration and read/bypass muxes.

## Test plan
- Reset then read all addresses: reg_data1/2 = 0, busy 0, pending_cnt 0, err 0.
- ALU write 0xA5 to r3, read r3 same cycle: BYPASS=1 gives 0xA5 immediately. BYPASS=0 gives 0x00, then 0xA5 next cycle.
- Reserve r7 (ack=1), next cycle reserve r7 again: ack=0, stall=1, pending_cnt=1. mem write 0x3C to r7: busy1 for r7 drops and reg_data = 0x3C.
- Same cycle: alu and mem write r9 with 0x11/0x22. Next cycle r9 reads 0x22 and err=1.
- Same cycle: mem releases r4 and rsv_en on r4. Result: rsv_ack=1, r4 still busy next cycle, data written, pending_cnt unchanged.
- Write 0xFF and reserve on r0: r0 reads 0, busy 0, pending_cnt 0. Assert reset mid-run: all outputs back to reset values without a clock edge.
